// File: rtl/gpu_pkg.sv
// Shared GPU datapath types: RGB444 colour struct, the error colour,
// texture geometry defaults and the per-channel shade helper.
package gpu_pkg;

  localparam int TEX_DIM_LOG2_DEF = 6;
  localparam int TEX_ID_WIDTH_DEF = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } color_t;

  // Magenta marks samples that addressed a texture slot that does not exist.
  localparam color_t ERROR_COLOR = 12'hF0F;

  // Darken a colour by logically shifting each 4-bit channel right.
  function automatic color_t shade_color(input color_t c, input logic [1:0] s);
    color_t o;
    o.r = c.r >> s;
    o.g = c.g >> s;
    o.b = c.b >> s;
    return o;
  endfunction

endpackage

// File: rtl/texture_sampler_if.sv
// Request, texture RAM read port and result stream of the texture sampler.
// master = the surrounding pipeline/RAM, slave = texture_sampler.
interface texture_sampler_if
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 22,
  parameter int COLOR_WIDTH  = 12,
  parameter int TEX_ID_WIDTH = TEX_ID_WIDTH_DEF,
  parameter int TEX_DIM_LOG2 = TEX_DIM_LOG2_DEF,
  parameter int TAG_WIDTH    = 20
);

  logic                    req_valid;
  logic                    req_ready;
  logic [TEX_ID_WIDTH-1:0] req_tex_id;
  logic [TEX_DIM_LOG2-1:0] req_u;
  logic [TEX_DIM_LOG2-1:0] req_v;
  logic [1:0]              req_shade;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic [COLOR_WIDTH-1:0]  rcolor;
  logic                    out_valid;
  logic                    out_ready;
  logic [COLOR_WIDTH-1:0]  out_color;
  logic [TAG_WIDTH-1:0]    out_tag;

  modport master (
    output req_valid, req_tex_id, req_u, req_v, req_shade, req_tag,
    output rcolor, out_ready,
    input  req_ready, raddr, out_valid, out_color, out_tag
  );

  modport slave (
    input  req_valid, req_tex_id, req_u, req_v, req_shade, req_tag,
    input  rcolor, out_ready,
    output req_ready, raddr, out_valid, out_color, out_tag
  );

endinterface

// File: rtl/gpu_fifo.sv
// Show-ahead synchronous FIFO shared by GPU pipeline stages.
// dout_o always presents the head entry; pop consumes it. DEPTH is a power
// of two so pointers wrap naturally. Storage is not reset, only pointers/count.
module gpu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gpu_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Guard against underflow/overflow so a misbehaving producer cannot corrupt state.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointer and occupancy; simultaneous push and pop keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and count, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written on push only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/texture_sampler.sv
// Texture sampler: turns texel requests into texture RAM reads, captures the
// returned colour one cycle later, optionally darkens it and queues it with
// its tag for the downstream stage. The RAM port never stalls, so request
// acceptance is credit-based on FIFO occupancy plus the in-flight read.
// Optional feature macro: TEXTURE_SAMPLER_SHADE_EN (enables req_shade).
module texture_sampler
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 22,
  parameter int COLOR_WIDTH  = 12,
  parameter int TEX_DIM_LOG2 = TEX_DIM_LOG2_DEF,
  parameter int TEX_ID_WIDTH = TEX_ID_WIDTH_DEF,
  parameter int TEX_COUNT    = 16,
  parameter int TAG_WIDTH    = 20,
  parameter int FIFO_DEPTH   = 4
) (
  input logic              clk,
  input logic              rst,
  texture_sampler_if.slave bus
);

  localparam int IDX_W = TEX_ID_WIDTH + 2 * TEX_DIM_LOG2;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = COLOR_WIDTH + TAG_WIDTH;

  if (ADDR_WIDTH < IDX_W) begin : g_bad_addr
    $error("texture_sampler: ADDR_WIDTH cannot hold {tex_id, v, u}");
  end
  if (TEX_COUNT > (1 << TEX_ID_WIDTH)) begin : g_bad_count
    $error("texture_sampler: TEX_COUNT exceeds the texture id range");
  end
  if (COLOR_WIDTH != $bits(color_t)) begin : g_bad_color
    $error("texture_sampler: COLOR_WIDTH must match RGB444");
  end

  logic                  accept;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        credits_used;
  logic                  fifo_empty;
  logic                  unused_fifo_full;
  logic [ENT_W-1:0]      fifo_head;
  logic                  pop;

  logic                  vld_p1_q;
  logic [TAG_WIDTH-1:0]  tag_p1_q;
  logic [1:0]            shade_p1_q;
  logic                  err_p1_q;
  color_t                color_p1;

  // ---- stage p0: request accept and RAM address ----
  assign bus.raddr = ADDR_WIDTH'({bus.req_tex_id, bus.req_v, bus.req_u});

  // Buffered entries plus the read in flight must leave room for one more.
  assign credits_used  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, vld_p1_q};
  assign bus.req_ready = ~rst & (credits_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;

  // In-flight flag: one read is outstanding for the cycle after an accept.
  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= accept;
  end

  // Sideband that travels with the read; data only, so left unreset.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_p1_q   <= bus.req_tag;
      shade_p1_q <= bus.req_shade;
      err_p1_q   <= ({1'b0, bus.req_tex_id} >= (TEX_ID_WIDTH + 1)'(TEX_COUNT));
    end
  end

  // ---- stage p1: RAM data returns, colour select, FIFO push ----
  // Colour mux: out-of-range textures show the error colour, never shaded.
  always_comb begin
    color_p1 = color_t'(bus.rcolor);
`ifdef TEXTURE_SAMPLER_SHADE_EN
    color_p1 = shade_color(color_t'(bus.rcolor), shade_p1_q);
`endif
    if (err_p1_q) color_p1 = ERROR_COLOR;
  end

`ifndef TEXTURE_SAMPLER_SHADE_EN
  logic unused_shade;
  assign unused_shade = ^shade_p1_q;
`endif

  gpu_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_p1_q),
    .din_i   ({color_p1, tag_p1_q}),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty)
  );

  // ---- stage p2: show-ahead result stream ----
  assign bus.out_valid = ~rst & ~fifo_empty;
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_color = bus.out_valid ? fifo_head[ENT_W-1 -: COLOR_WIDTH] : '0;
  assign bus.out_tag   = bus.out_valid ? fifo_head[TAG_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_texture_sampler.sv
// Testbench for texture_sampler: randomized requests against a texture RAM
// model and a reference queue of expected {colour, tag} results.
// Honors TEXTURE_SAMPLER_SHADE_EN when computing expected colours.
module tb_texture_sampler;

  localparam int TEX_COUNT  = 12;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  texture_sampler_if #(
    .ADDR_WIDTH(22), .COLOR_WIDTH(12), .TEX_ID_WIDTH(4),
    .TEX_DIM_LOG2(6), .TAG_WIDTH(20)
  ) bus ();

  texture_sampler #(
    .ADDR_WIDTH(22), .COLOR_WIDTH(12), .TEX_DIM_LOG2(6), .TEX_ID_WIDTH(4),
    .TEX_COUNT(TEX_COUNT), .TAG_WIDTH(20), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [11:0] ram [65536];

  // Synchronous RAM: data for the address of one cycle appears the next.
  always @(posedge clk) bus.rcolor <= ram[bus.raddr[15:0]];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int outstanding = 0;
  int max_out = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  int          pop_cyc [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Reference: address -> texel, invalid id -> magenta, optional channel shift.
  function automatic logic [11:0] model_color(input int id, input int u, input int v, input int sh);
    int c;
    if (id >= TEX_COUNT) return 12'hF0F;
    c = int'(ram[id * 4096 + v * 64 + u]);
`ifdef TEXTURE_SAMPLER_SHADE_EN
    c = ((c / 256) >> sh) * 256 + (((c / 16) % 16) >> sh) * 16 + ((c % 16) >> sh);
`else
    c = c + 0 * sh;
`endif
    return c[11:0];
  endfunction

  task automatic tick();
    @(negedge clk);
    if (!rst && bus.req_valid && bus.req_ready) begin
      exp_q.push_back({model_color(int'(bus.req_tex_id), int'(bus.req_u), int'(bus.req_v),
                                   int'(bus.req_shade)), bus.req_tag});
      outstanding++;
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_q.push_back({bus.out_color, bus.out_tag});
      pop_cyc.push_back(cyc);
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    pop_cyc.delete();
    outstanding = 0;
    max_out = 0;
  endtask

  task automatic rand_req(input int id_lo, input int id_hi);
    bus.req_tex_id = 4'($urandom_range(id_hi, id_lo));
    bus.req_u      = 6'($urandom_range(63, 0));
    bus.req_v      = 6'($urandom_range(63, 0));
    bus.req_shade  = 2'($urandom_range(3, 0));
    bus.req_tag    = 20'($urandom);
  endtask

  task automatic drain(input int budget, output bit timed_out);
    int n = 0;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (got_q.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    timed_out = (got_q.size() < exp_q.size());
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_color !== 12'h000) begin miscompares++; $display("FAIL reset_out_color: got %h want 000", bus.out_color); end
    vectors++; if (bus.out_tag !== 20'h0) begin miscompares++; $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); end
    rst = 1'b0;
    tick();
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b want 1", bus.req_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_single();
    logic [19:0] tag;
    bit to;
    clear_model();
    ram[16'h21C5] = 12'h8C4;
    tag = 20'($urandom);
    bus.out_ready = 1'b1;
    bus.req_tex_id = 4'd2; bus.req_u = 6'd5; bus.req_v = 6'd7;
    bus.req_shade = 2'd0; bus.req_tag = tag; bus.req_valid = 1'b1;
    #1;
    vectors++; if (bus.raddr !== 22'h0021C5) begin miscompares++; $display("FAIL single_raddr: got %h want 0021c5", bus.raddr); end
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b want 0", bus.out_valid); end
    tick();
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_latency: out_valid got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_color !== 12'h8C4) begin miscompares++; $display("FAIL single_color: got %h want 8c4", bus.out_color); end
    vectors++; if (bus.out_tag !== tag) begin miscompares++; $display("FAIL single_tag: got %h want %h", bus.out_tag, tag); end
    drain(10, to);
    vectors++; if (to || got_q.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    bit to;
    clear_model();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rand_req(0, 15);
      bus.req_valid = 1'b1;
      if (bus.req_ready !== 1'b1) drops++;
      tick();
    end
    drain(20, to);
    vectors++; if (to) begin miscompares++; $display("FAIL b2b_drain: got %0d outputs want %0d", got_q.size(), exp_q.size()); end
    vectors++; if (drops != 0) begin miscompares++; $display("FAIL b2b_ready_drops: got %0d want 0", drops); end
    vectors++; if (got_q.size() != 64) begin miscompares++; $display("FAIL b2b_count: got %0d want 64", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (pop_cyc.size() == 64) begin
      vectors++;
      if (pop_cyc[63] - pop_cyc[0] != 63) begin miscompares++; $display("FAIL b2b_throughput: span %0d want 63", pop_cyc[63] - pop_cyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    int guard = 0;
    logic acc;
    bit to;
    clear_model();
    bus.out_ready = 1'b0;
    rand_req(0, 15);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      acc = bus.req_ready;
      tick();
      if (acc) begin accepts++; rand_req(0, 15); end
    end
    vectors++; if (accepts != FIFO_DEPTH) begin miscompares++; $display("FAIL bp_accepts: got %0d want %0d", accepts, FIFO_DEPTH); end
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low: got %b want 0", bus.req_ready); end
    bus.out_ready = 1'b1;
    while (accepts < 12 && guard < 50) begin
      acc = bus.req_ready;
      tick();
      guard++;
      if (acc) begin accepts++; rand_req(0, 15); end
    end
    drain(20, to);
    vectors++; if (to || got_q.size() != 12) begin miscompares++; $display("FAIL bp_count: got %0d want 12", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (max_out > FIFO_DEPTH) begin miscompares++; $display("FAIL bp_overflow: outstanding %0d limit %0d", max_out, FIFO_DEPTH); end
  endtask

  task automatic test_error_texture();
    logic [11:0] c;
    bit to;
    clear_model();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_req(TEX_COUNT, 15);
      if (i == 0) bus.req_tex_id = 4'd15;
      bus.req_valid = 1'b1;
      tick();
    end
    drain(20, to);
    vectors++; if (to || got_q.size() != 6) begin miscompares++; $display("FAIL err_count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      c = got_q[i][31:20];
      vectors++;
      if (c !== 12'hF0F) begin miscompares++; $display("FAIL err_color[%0d]: got %h want f0f", i, c); end
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL err_entry[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_shade();
    logic [11:0] c, want;
    bit to;
    clear_model();
`ifdef TEXTURE_SAMPLER_SHADE_EN
    want = 12'h321;
`else
    want = 12'hFA6;
`endif
    ram[{4'd3, 6'd10, 6'd20}] = 12'hFA6;
    bus.out_ready = 1'b1;
    bus.req_tex_id = 4'd3; bus.req_v = 6'd10; bus.req_u = 6'd20;
    bus.req_shade = 2'd2; bus.req_tag = 20'($urandom); bus.req_valid = 1'b1;
    tick();
    drain(10, to);
    vectors++; if (to || got_q.size() != 1) begin miscompares++; $display("FAIL shade_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      c = got_q[0][31:20];
      vectors++;
      if (c !== want) begin miscompares++; $display("FAIL shade_color: got %h want %h", c, want); end
    end
  endtask

  task automatic test_reset_midstream();
    int accepts = 0;
    int guard = 0;
    logic acc;
    bit to;
    clear_model();
    bus.out_ready = 1'b0;
    rand_req(0, 15);
    bus.req_valid = 1'b1;
    while (accepts < 4 && guard < 20) begin
      acc = bus.req_ready;
      tick();
      guard++;
      if (acc) begin accepts++; rand_req(0, 15); end
    end
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ready: got %b want 0", bus.req_ready); end
    tick();
    rst = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_after_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_color !== 12'h000 || bus.out_tag !== 20'h0) begin miscompares++; $display("FAIL rst_after_data: got %h/%h want 0/0", bus.out_color, bus.out_tag); end
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_after_ready: got %b want 1", bus.req_ready); end
    clear_model();
    bus.out_ready = 1'b1;
    repeat (5) tick();
    vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL rst_stale: got %0d outputs want 0", got_q.size()); end
    rand_req(0, 15);
    bus.req_valid = 1'b1;
    tick();
    drain(10, to);
    vectors++; if (to || got_q.size() != 1) begin miscompares++; $display("FAIL rst_fresh_count: got %0d want 1", got_q.size()); end
    if (got_q.size() == 1 && exp_q.size() == 1) begin
      vectors++;
      if (got_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL rst_fresh_data: got %h want %h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_random_stream();
    logic acc;
    bit to;
    clear_model();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      acc = bus.req_valid & bus.req_ready;
      tick();
      if (acc || !bus.req_valid) begin
        bus.req_valid = ($urandom_range(3, 0) != 0);
        rand_req(0, 15);
      end
      bus.out_ready = ($urandom_range(3, 0) != 0);
    end
    drain(40, to);
    vectors++; if (to || got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (max_out > FIFO_DEPTH) begin miscompares++; $display("FAIL rand_overflow: outstanding %0d limit %0d", max_out, FIFO_DEPTH); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_tex_id = '0; bus.req_u = '0; bus.req_v = '0;
    bus.req_shade = '0; bus.req_tag = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 65536; i++) ram[i] = 12'($urandom);
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_error_texture();
    test_shade();
    test_reset_midstream();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/texture_sampler.md
Name: texture_sampler

Overview:
- Pixel-side consumer of the texture RAM read port.
- Accepts texel requests (texture id, u, v, sideband tag) on a valid/ready stream and drives the RAM's raddr.
- Captures rcolor one cycle after each read, optionally shades it, and buffers results in a small FIFO.
- Delivers colour+tag on a valid/ready stream to the downstream rasteriser/VGA stage. The RAM read port cannot stall; this block absorbs all backpressure.

Parameters:
- ADDR_WIDTH, 22, texture RAM address width.
- COLOR_WIDTH, 12, colour width; fixed as RGB444, R[11:8] G[7:4] B[3:0].
- TEX_DIM_LOG2, 6, log2 of texture edge; 64x64 texels.
- TEX_ID_WIDTH, 4, texture id width.
- TEX_COUNT, 16, number of valid textures; must be <= 2**TEX_ID_WIDTH.
- TAG_WIDTH, 20, opaque sideband width (e.g. screen x/y).
- FIFO_DEPTH, 4, output buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_tex_id  in  TEX_ID_WIDTH  texture index
- req_u  in  TEX_DIM_LOG2  column
- req_v  in  TEX_DIM_LOG2  row
- req_shade  in  2  brightness shift
- req_tag  in  TAG_WIDTH  sideband, passed through unchanged
- raddr  out  ADDR_WIDTH  texture RAM read address
- rcolor  in  COLOR_WIDTH  texture RAM data, valid one cycle after raddr
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_color  out  COLOR_WIDTH  sampled colour
- out_tag  out  TAG_WIDTH  tag of that sample

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- While rst is high:
  - req_ready=0, out_valid=0, out_color=0, out_tag=0.
  - FIFO count=0 and in-flight flag=0.
  - Asserting rst mid-operation drops all in-flight and buffered samples.
- raddr is combinational and always equals zero-extended {req_tex_id, req_v, req_u}; width TEX_ID_WIDTH+2*TEX_DIM_LOG2=16.
  - Elaboration error if ADDR_WIDTH is less than that width, or if TEX_COUNT > 2**TEX_ID_WIDTH.
- Accept: req_ready = (fifo_count + inflight) < FIFO_DEPTH. This is registered state only, with no combinational path from out_ready.
- Cycle t accept: latch inflight=1, tag, shade, and err = (req_tex_id >= TEX_COUNT).
- Cycle t+1:
  - Sample rcolor. If err, the colour is ERROR_COLOR 12'hF0F; otherwise it is the shaded rcolor.
  - Push {colour, tag} into the FIFO at the end of t+1.
  - inflight becomes the accept condition of t+1.
- out_valid is asserted from t+2. Minimum latency is 2 cycles; sustained throughput is 1 sample/cycle when out_ready stays high.
- FIFO is show-ahead: out_color/out_tag are the head entry; pop on out_valid&&out_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Push into a full FIFO cannot occur, because credit accounting prevents it. The bench asserts this.
- Results leave strictly in request order.
- Texture-RAM writes racing a read: whichever rcolor is present at t+1 is used; no hazard handling.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH. u/v never wrap here; the caller supplies in-range coordinates by width.

Optional Feature:
- TEXTURE_SAMPLER_SHADE_EN defined: each 4-bit channel is logically shifted right by req_shade (0..3) before the FIFO push. ERROR_COLOR is never shaded.
- Undefined: req_shade is ignored and colour passes unmodified. The port remains present.

Decomposition:
- Package gpu_pkg holds:
  - color_t (12-bit packed struct r,g,b of 4 bits).
  - ERROR_COLOR.
  - TEX_DIM_LOG2 and TEX_ID_WIDTH defaults.
  - A shade function.
- One sub-module: gpu_fifo, a parameterised show-ahead synchronous FIFO (WIDTH, DEPTH) with push/pop/count and synchronous rst. It is reused by later GPU stages.
- The sampler top holds the credit logic, the in-flight register and the colour mux.

Test Plan:
1. Single request tex_id=2, u=5, v=7, with RAM model returning 12'h8C4 at addr 0x21C5 -> raddr=0x21C5 in the accept cycle; out_valid 2 cycles later with out_color=12'h8C4 and tag unchanged.
2. 64 back-to-back requests with out_ready=1 -> req_ready never drops after the first cycle; 64 outputs in order, one per cycle.
3. out_ready=0 while streaming -> exactly 4 requests accepted, then req_ready=0. Raise out_ready -> 4 outputs in order, then the stream resumes with no loss or duplication.
4. tex_id=15 with TEX_COUNT=12 -> out_color=12'hF0F regardless of rcolor.
5. With the macro defined, rcolor=12'hFA6 and shade=2 -> out_color=12'h321. Without the macro -> 12'hFA6.
6. Assert rst for 1 cycle with 3 buffered and 1 in flight -> next cycle out_valid=0, outputs 0, and req_ready=1 after rst deasserts; no stale outputs appear.
